sha_scan_core: RTL
==================

Name: sha_scan_core

Overview:
Parametrised successor of the single-nonce SHA core. It sequences LANES external 64-round SHA engines in lockstep, issues consecutive nonces to the lanes, and compares each lane's top hash word against a programmable target. Hits go into a result FIFO with a valid/ready handshake. It sits between the host/work interface and the array of sha256 engines.

Parameters:
LANES, 4, number of parallel hash lanes; power of two, 1..16
ROUNDS, 64, engine cycles per hash; must be >= LANES+1
FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2
LW, $clog2(LANES) (min 1), lane index width (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins scan when idle
stop  in  1  one-cycle pulse; aborts scan
nonce_start  in  32  first nonce, sampled on accepted start
nonce_end  in  32  last nonce inclusive, sampled on accepted start
target  in  32  hit when hash_top word <= target (unsigned), sampled on start
cycle  out  6  round index driven to all engines
lane_nonce  out  32*LANES  lane i nonce at bits [32i+31:32i] = base+i (mod 2^32)
hash_top  in  32*LANES  engine hash[255:224] per lane, valid when cycle==ROUNDS-1
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer accepts head
res_nonce  out  32  nonce of head hit
res_lane  out  LW  lane of head hit
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse on normal completion
overflow  out  1  sticky: hit dropped on full FIFO; cleared by accepted start or reset

Behaviour:
- Reset (n_rst low at clk edge): state IDLE, cycle=0, base=0, lane_nonce=0, pending mask=0, FIFO empty, res_valid=0, res_nonce=0, res_lane=0, busy=0, done=0, overflow=0. Overrides all other inputs, including mid-scan.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 and stop=0 -> RUN. Latches base=nonce_start, end, and target. Sets cycle=0 and clears overflow. start together with stop in IDLE: no action.
- RUN: cycle increments each clock, 0..ROUNDS-1, then wraps to 0. lane_nonce stays stable for a whole batch.
- At cycle==ROUNDS-1:
  - Lane i is eligible iff i <= (end-base), computed as 32-bit unsigned modulo difference.
  - Hit mask = eligible & (hash_top_i <= target). It is ORed into the pending mask with the batch base saved as pend_base. The pending mask is guaranteed empty by this time because ROUNDS > LANES.
  - Last batch iff (end-base) < LANES. Last batch -> DRAIN, cycle holds 0. Otherwise base += LANES (wraps mod 2^32).
- Pending drain, in RUN and DRAIN: each clock, the lowest set pending bit j is cleared and {pend_base+j, j} is pushed. If the FIFO is full, the entry is dropped and overflow is set. One push per clock at most.
- DRAIN: when the pending mask is zero -> IDLE. done pulses for one cycle on that transition.
- stop=1 in RUN/DRAIN -> IDLE next clock. Pending is cleared, cycle=0, no done pulse, FIFO contents kept. stop has priority over start.
- start while busy: ignored.
- FIFO: standard valid/ready. Pop occurs when res_valid&res_ready. Simultaneous push and pop when full: pop first, push accepted, no overflow. Head outputs are registered, first-word-fall-through: an entry pushed at edge N is visible after edge N.
- nonce_start==nonce_end: single batch, only lane 0 eligible.
- Range wrapping through 0xFFFFFFFF->0 is legal. Eligibility and the last-batch test use modulo difference, so wrap is transparent.

Test Plan:
- LANES=4: nonce_start=0x10, nonce_end=0x1B, target=0, hash_top all 0xFFFFFFFF -> 3 batches (bases 0x10, 0x14, 0x18), each ROUNDS cycles; done pulses once; FIFO empty; overflow=0.
- Same range, hash_top lane2=0x00000000 only in batch base 0x14 -> one result: res_nonce=0x16, res_lane=2.
- nonce_start=0xFFFFFFFE, nonce_end=0x00000000, all lanes hit -> results 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (lanes 0..2); lane 3 (0x00000001) masked.
- FIFO_DEPTH=4, res_ready=0, all 4 lanes hit in 2 batches -> 4 entries held, remaining 4 dropped, overflow=1. Next start clears overflow.
- stop asserted at cycle=30 of batch 2 -> IDLE next clock, busy=0, no done, earlier results still poppable.
- n_rst low for one clock during RUN with res_valid=1 -> all outputs at reset values next cycle; subsequent start runs normally.

Source files
------------

// File: rtl/sha_scan_core.sv
// Scan sequencer for LANES lockstep SHA engines: issues nonce batches, compares
// each lane's top hash word against a target and queues hits in a result FIFO.
module sha_scan_core #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned ROUNDS     = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           nonce_start,
    input  logic [31:0]           nonce_end,
    input  logic [31:0]           target,
    output logic [5:0]            cycle,
    output logic [32*LANES-1:0]   lane_nonce,
    input  logic [32*LANES-1:0]   hash_top,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_nonce,
    output logic [LW-1:0]         res_lane,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_n;

    logic [5:0]          cycle_n;
    logic [31:0]         base, base_n, end_r, end_n, target_r, target_n;
    logic [31:0]         pend_base, pend_base_n, diff;
    logic [32*LANES-1:0] lane_nonce_n;
    logic [LANES-1:0]    pend, pend_n, low_bit, hit;
    logic [LW-1:0]       low_idx;
    logic                done_n, overflow_n, busy_n;

    logic                push, push_ok, pop;
    logic [31:0]         push_nonce;
    logic [LW-1:0]       push_lane;
    logic [31:0]         mem_nonce [FIFO_DEPTH];
    logic [LW-1:0]       mem_lane  [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr, rd_n, wr_ptr, wr_n;
    logic [CW-1:0]       cnt, cnt_n, cnt_kept;
    logic                res_valid_n;
    logic [31:0]         res_nonce_n;
    logic [LW-1:0]       res_lane_n;

    function automatic logic [32*LANES-1:0] spread(input logic [31:0] b);
        logic [32*LANES-1:0] v;
        for (int i = 0; i < LANES; i++) v[32*i +: 32] = b + 32'(i);
        return v;
    endfunction

    // Next-state, batch sequencing, pending drain and FIFO bookkeeping
    always_comb begin
        state_n      = state;
        cycle_n      = cycle;
        base_n       = base;
        end_n        = end_r;
        target_n     = target_r;
        pend_n       = pend;
        pend_base_n  = pend_base;
        lane_nonce_n = lane_nonce;
        overflow_n   = overflow;
        done_n       = 1'b0;
        push         = 1'b0;
        diff         = end_r - base;
        low_bit      = pend & (~pend + LANES'(1));
        low_idx      = '0;
        for (int i = LANES - 1; i >= 0; i--) if (pend[i]) low_idx = LW'(i);
        for (int i = 0; i < LANES; i++)
            hit[i] = (32'(i) <= diff) && (hash_top[32*i +: 32] <= target_r);
        push_nonce = pend_base + 32'(low_idx);
        push_lane  = low_idx;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n      = RUN;
                    base_n       = nonce_start;
                    end_n        = nonce_end;
                    target_n     = target;
                    cycle_n      = '0;
                    overflow_n   = 1'b0;
                    lane_nonce_n = spread(nonce_start);
                end
            end
            RUN, DRAIN: begin
                if (stop) begin
                    state_n = IDLE;
                    pend_n  = '0;
                    cycle_n = '0;
                end else begin
                    if (pend != '0) begin
                        push   = 1'b1;
                        pend_n = pend & ~low_bit;
                    end
                    if (state == RUN) begin
                        if (cycle == 6'(ROUNDS - 1)) begin
                            pend_n      = pend_n | hit;
                            pend_base_n = base;
                            cycle_n     = '0;
                            if (diff < 32'(LANES)) begin
                                state_n = DRAIN;
                            end else begin
                                base_n       = base + 32'(LANES);
                                lane_nonce_n = spread(base + 32'(LANES));
                            end
                        end else begin
                            cycle_n = cycle + 6'd1;
                        end
                    end else if (pend == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Pop is applied before push so a full FIFO can accept on a popping cycle
        pop      = res_valid & res_ready;
        cnt_kept = cnt - CW'(pop);
        push_ok  = push && (cnt_kept < CW'(FIFO_DEPTH));
        if (push && !push_ok) overflow_n = 1'b1;
        cnt_n       = cnt_kept + CW'(push_ok);
        rd_n        = rd_ptr + PW'(pop);
        wr_n        = wr_ptr + PW'(push_ok);
        res_valid_n = (cnt_n != '0);
        res_nonce_n = res_nonce;
        res_lane_n  = res_lane;
        if (cnt_kept != '0) begin
            res_nonce_n = mem_nonce[rd_n];
            res_lane_n  = mem_lane[rd_n];
        end else if (push_ok) begin
            res_nonce_n = push_nonce;
            res_lane_n  = push_lane;
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            cycle      <= '0;
            base       <= '0;
            end_r      <= '0;
            target_r   <= '0;
            pend       <= '0;
            pend_base  <= '0;
            lane_nonce <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            res_valid  <= 1'b0;
            res_nonce  <= '0;
            res_lane   <= '0;
        end else begin
            state      <= state_n;
            cycle      <= cycle_n;
            base       <= base_n;
            end_r      <= end_n;
            target_r   <= target_n;
            pend       <= pend_n;
            pend_base  <= pend_base_n;
            lane_nonce <= lane_nonce_n;
            overflow   <= overflow_n;
            done       <= done_n;
            busy       <= busy_n;
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_n;
            cnt        <= cnt_n;
            res_valid  <= res_valid_n;
            res_nonce  <= res_nonce_n;
            res_lane   <= res_lane_n;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst && push_ok) begin
            mem_nonce[wr_ptr] <= push_nonce;
            mem_lane[wr_ptr]  <= push_lane;
        end
    end
endmodule
